// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer: NS/EW green-yellow-all-red cycle with walk and emergency hold.
// Define PED_LATCH_EN to latch pedestrian presses; otherwise the raw button level is used.
module traffic_phase_sequencer #(
    parameter int unsigned TIMER_W     = 8,
    parameter int unsigned GREEN_DAY   = 20,
    parameter int unsigned GREEN_NIGHT = 40,
    parameter int unsigned GREEN_PED   = 8,
    parameter int unsigned YELLOW_T    = 3,
    parameter int unsigned RED_T       = 2,
    parameter int unsigned WALK_T      = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               emergency,
    input  logic               pedestrian,
    input  logic               dayNight,
    output logic [2:0]         nsLight,
    output logic [2:0]         ewLight,
    output logic               walk,
    output logic               emergencyActive,
    output logic [TIMER_W-1:0] phaseTimer
);

    typedef enum logic [2:0] {
        AllRed,
        NsGreen,
        NsYellow,
        EwGreen,
        EwYellow,
        Walk,
        EmergHold
    } stateT;

    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    localparam logic [TIMER_W-1:0] LdDay    = TIMER_W'(GREEN_DAY - 1);
    localparam logic [TIMER_W-1:0] LdNight  = TIMER_W'(GREEN_NIGHT - 1);
    localparam logic [TIMER_W-1:0] LdPed    = TIMER_W'(GREEN_PED - 1);
    localparam logic [TIMER_W-1:0] LdYellow = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] LdRed    = TIMER_W'(RED_T - 1);
    localparam logic [TIMER_W-1:0] LdWalk   = TIMER_W'(WALK_T - 1);

    stateT              stateQ, stateD;
    logic [TIMER_W-1:0] timerQ, timerD;
    logic               nextDirQ, nextDirD;  // 0 = NS next, 1 = EW next
    logic               pedEff;
    logic [TIMER_W-1:0] greenLoad;
    stateT              greenState;

    assign greenLoad  = pedEff ? LdPed : (dayNight ? LdNight : LdDay);
    assign greenState = nextDirQ ? EwGreen : NsGreen;

    always_comb begin
        stateD   = stateQ;
        timerD   = (timerQ != '0) ? timerQ - TIMER_W'(1) : '0;
        nextDirD = nextDirQ;
        case (stateQ)
            NsGreen, EwGreen: begin
                // Emergency cuts green short but yellow always runs its full length.
                if (emergency || timerQ == '0) begin
                    stateD = (stateQ == NsGreen) ? NsYellow : EwYellow;
                    timerD = LdYellow;
                end
            end
            NsYellow, EwYellow: begin
                if (timerQ == '0) begin
                    stateD   = AllRed;
                    timerD   = LdRed;
                    nextDirD = (stateQ == NsYellow);
                end
            end
            AllRed: begin
                if (timerQ == '0) begin
                    if (emergency) begin
                        stateD = EmergHold;
                        timerD = '0;
                    end else if (pedEff) begin
                        stateD = Walk;
                        timerD = LdWalk;
                    end else begin
                        stateD = greenState;
                        timerD = greenLoad;
                    end
                end
            end
            Walk: begin
                if (emergency) begin
                    stateD = EmergHold;
                    timerD = '0;
                end else if (timerQ == '0) begin
                    stateD = greenState;
                    timerD = greenLoad;
                end
            end
            EmergHold: begin
                timerD = '0;
                if (!emergency) begin
                    stateD = AllRed;
                    timerD = LdRed;
                end
            end
            default: begin
                stateD = AllRed;
                timerD = LdRed;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ   <= AllRed;
            timerQ   <= LdRed;
            nextDirQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            timerQ   <= timerD;
            nextDirQ <= nextDirD;
        end
    end

`ifdef PED_LATCH_EN
    logic pedPendingQ, pedPendingD;

    // Clear on WALK entry takes priority over a press in the same cycle.
    always_comb begin
        pedPendingD = pedPendingQ;
        if (stateQ != Walk && pedestrian) begin
            pedPendingD = 1'b1;
        end
        if (stateD == Walk && stateQ != Walk) begin
            pedPendingD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pedPendingQ <= 1'b0;
        end else begin
            pedPendingQ <= pedPendingD;
        end
    end

    assign pedEff = pedPendingQ;
`else
    assign pedEff = pedestrian;
`endif

    always_comb begin
        nsLight         = LampRed;
        ewLight         = LampRed;
        walk            = 1'b0;
        emergencyActive = 1'b0;
        case (stateQ)
            NsGreen:   nsLight = LampGreen;
            NsYellow:  nsLight = LampYellow;
            EwGreen:   ewLight = LampGreen;
            EwYellow:  ewLight = LampYellow;
            Walk:      walk = 1'b1;
            EmergHold: emergencyActive = 1'b1;
            default: ;
        endcase
    end

    assign phaseTimer = timerQ;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer: phase/remaining-cycles reference model,
// directed test-plan scenarios followed by randomized requests and resets.
module tb_traffic_phase_sequencer;

    localparam int TW = 8;
    localparam int GD = 20;
    localparam int GN = 40;
    localparam int GP = 8;
    localparam int YT = 3;
    localparam int RT = 2;
    localparam int WT = 6;

    localparam int P_AR = 0, P_NG = 1, P_NY = 2, P_EG = 3, P_EY = 4, P_WK = 5, P_EH = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          emergency = 1'b0;
    logic          pedestrian = 1'b0;
    logic          dayNight = 1'b0;
    logic [2:0]    nsLight, ewLight;
    logic          walk, emergencyActive;
    logic [TW-1:0] phaseTimer;

    traffic_phase_sequencer #(
        .TIMER_W(TW), .GREEN_DAY(GD), .GREEN_NIGHT(GN), .GREEN_PED(GP),
        .YELLOW_T(YT), .RED_T(RT), .WALK_T(WT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .emergency(emergency), .pedestrian(pedestrian),
        .dayNight(dayNight), .nsLight(nsLight), .ewLight(ewLight), .walk(walk),
        .emergencyActive(emergencyActive), .phaseTimer(phaseTimer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    ns;
        logic [2:0]    ew;
        logic          wk;
        logic          em;
        logic [TW-1:0] tmr;
    } obsT;

    obsT expQ[$];
    int  checks = 0;
    int  failures = 0;

    // Reference model: current phase and cycles remaining in it (1 = last cycle).
    int mPhase;
    int mRem;
    bit mDirEw;
    bit mPed;

    task automatic modelReset();
        mPhase = P_AR;
        mRem   = RT;
        mDirEw = 1'b0;
        mPed   = 1'b0;
    endtask

    function automatic int greenLen(bit p, bit night);
        if (p) return GP;
        if (night) return GN;
        return GD;
    endfunction

    function automatic obsT modelObs();
        obsT o;
        o.ns  = (mPhase == P_NG) ? 3'b001 : (mPhase == P_NY) ? 3'b010 : 3'b100;
        o.ew  = (mPhase == P_EG) ? 3'b001 : (mPhase == P_EY) ? 3'b010 : 3'b100;
        o.wk  = (mPhase == P_WK);
        o.em  = (mPhase == P_EH);
        o.tmr = TW'(mRem - 1);
        return o;
    endfunction

    task automatic modelStep(input bit em, input bit ped, input bit night);
        bit pe;
        int nPhase, nRem;
        bit nDir;
`ifdef PED_LATCH_EN
        pe = mPed;
`else
        pe = ped;
`endif
        nPhase = mPhase;
        nRem   = (mRem > 1) ? mRem - 1 : 1;
        nDir   = mDirEw;
        case (mPhase)
            P_NG, P_EG: if (em || mRem == 1) begin
                nPhase = (mPhase == P_NG) ? P_NY : P_EY;
                nRem   = YT;
            end
            P_NY, P_EY: if (mRem == 1) begin
                nDir   = (mPhase == P_NY);
                nPhase = P_AR;
                nRem   = RT;
            end
            P_AR: if (mRem == 1) begin
                if (em) begin
                    nPhase = P_EH; nRem = 1;
                end else if (pe) begin
                    nPhase = P_WK; nRem = WT;
                end else begin
                    nPhase = mDirEw ? P_EG : P_NG; nRem = greenLen(pe, night);
                end
            end
            P_WK: begin
                if (em) begin
                    nPhase = P_EH; nRem = 1;
                end else if (mRem == 1) begin
                    nPhase = mDirEw ? P_EG : P_NG; nRem = greenLen(pe, night);
                end
            end
            P_EH: if (!em) begin
                nPhase = P_AR; nRem = RT;
            end
            default: ;
        endcase
`ifdef PED_LATCH_EN
        if (nPhase == P_WK && mPhase != P_WK) mPed = 1'b0;
        else if (mPhase != P_WK && ped) mPed = 1'b1;
`endif
        mPhase = nPhase;
        mRem   = nRem;
        mDirEw = nDir;
    endtask

    // Called at posedge+1: drive inputs, queue what the DUT must show this cycle, advance model.
    task automatic cycle(input bit rstn, input bit em, input bit ped, input bit night);
        rst_n      = rstn;
        emergency  = em;
        pedestrian = ped;
        dayNight   = night;
        if (!rstn) modelReset();
        expQ.push_back(modelObs());
        if (rstn) modelStep(em, ped, night);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        obsT e, a;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = {nsLight, ewLight, walk, emergencyActive, phaseTimer};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got ns=%b ew=%b walk=%b emAct=%b tmr=%0d want ns=%b ew=%b walk=%b emAct=%b tmr=%0d",
                         $time, a.ns, a.ew, a.wk, a.em, a.tmr, e.ns, e.ew, e.wk, e.em, e.tmr);
            end
            checks++;
            if (!$onehot(nsLight) || !$onehot(ewLight) ||
                (nsLight != 3'b100 && ewLight != 3'b100)) begin
                failures++;
                $display("FAIL lampInvariant t=%0t got ns=%b ew=%b want one-hot with at least one red",
                         $time, nsLight, ewLight);
            end
        end
    end

    initial begin
        bit em, ped, night, found;
        int emLeft, pedLeft;
        modelReset();
        @(posedge clk);
        #1;

        // Day, no requests.
        doReset();
        for (int k = 0; k < 60; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Night from the start: 40-cycle green.
        doReset();
        for (int k = 0; k < 60; k++) cycle(1'b1, 1'b0, 1'b0, 1'b1);

        // Single pedestrian pulse at cycle 5.
        doReset();
        for (int k = 0; k < 70; k++) cycle(1'b1, 1'b0, (k == 5), 1'b0);

        // Emergency held over cycles 10..29.
        doReset();
        for (int k = 0; k < 70; k++) cycle(1'b1, (k >= 10 && k < 30), 1'b0, 1'b0);

        // Emergency and pedestrian together at the first ALL_RED exit.
        doReset();
        for (int k = 0; k < 80; k++) cycle(1'b1, (k < 6), (k == 1), 1'b0);

        // Reset in the middle of EW_YELLOW, then the plain sequence again.
        doReset();
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (mPhase == P_EY && mRem == 2) found = 1'b1;
            else cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reachEwYellow got not reached want reached within 200 cycles");
        end
        doReset();
        for (int k = 0; k < 40; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized requests with occasional asynchronous resets.
        emLeft  = 0;
        pedLeft = 0;
        night   = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (emLeft == 0 && $urandom_range(0, 99) == 0) emLeft = $urandom_range(1, 25);
            if (pedLeft == 0 && $urandom_range(0, 11) == 0) pedLeft = $urandom_range(1, 3);
            if ($urandom_range(0, 199) == 0) night = ~night;
            em  = (emLeft > 0);
            ped = (pedLeft > 0);
            if (emLeft > 0) emLeft--;
            if (pedLeft > 0) pedLeft--;
            if ($urandom_range(0, 599) == 0) cycle(1'b0, em, ped, night);
            else cycle(1'b1, em, ped, night);
        end

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending want 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
